// File: rtl/id_ex_stage_register_pkg.sv
// rtl/id_ex_stage_register_pkg.sv - shared FSM state, control-bundle layout and NOP word for the ID/EX register
package id_ex_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } drain_state_e;

  // Bit offsets inside the packed 16-bit control bundle.
  localparam int CTRL_REGDST_BIT   = 0;
  localparam int CTRL_REGWRITE_BIT = 1;
  localparam int CTRL_ALUSRC_BIT   = 2;
  localparam int CTRL_ALUOP_LSB    = 3;
  localparam int CTRL_ALUOP_W      = 2;
  localparam int CTRL_MEMREAD_BIT  = 5;
  localparam int CTRL_MEMWRITE_BIT = 6;
  localparam int CTRL_MEMTOREG_BIT = 7;
  localparam int CTRL_ALUCTRL_LSB  = 8;
  localparam int CTRL_ALUCTRL_W    = 4;
  localparam int CTRL_SELBYTES_LSB = 12;
  localparam int CTRL_SELBYTES_W   = 2;
  localparam int CTRL_BRANCH_BIT   = 14;

  localparam logic [15:0] CTRL_NOP_DEFAULT = 16'h0200;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/id_ex_stage_register_if.sv
// rtl/id_ex_stage_register_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_register_if #(
  parameter int CANT_BITS_ADDR      = 11,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_IMMEDIATE = 16,
  parameter int CANT_BITS_CTRL      = 16
);
  localparam int RBITS = $clog2(CANT_REGISTROS);

  logic                           i_enable_pipeline;
  logic                           i_valid;
  logic                           i_bubble;
  logic                           i_flush;
  logic                           i_halt;
  logic                           i_zero_extend;
  logic [CANT_BITS_ADDR-1:0]      i_pc;
  logic [CANT_BITS_REGISTROS-1:0] i_data_A;
  logic [CANT_BITS_REGISTROS-1:0] i_data_B;
  logic [CANT_BITS_IMMEDIATE-1:0] i_immediate;
  logic [RBITS-1:0]               i_reg_rs;
  logic [RBITS-1:0]               i_reg_rt;
  logic [RBITS-1:0]               i_reg_rd;
  logic [CANT_BITS_CTRL-1:0]      i_ctrl;
  logic                           i_control_write_reg;
  logic [RBITS-1:0]               i_reg_write;
  logic [CANT_BITS_REGISTROS-1:0] i_data_write;

  logic                           o_valid;
  logic [CANT_BITS_ADDR-1:0]      o_pc;
  logic [CANT_BITS_REGISTROS-1:0] o_data_A;
  logic [CANT_BITS_REGISTROS-1:0] o_data_B;
  logic [CANT_BITS_REGISTROS-1:0] o_extension_constante;
  logic [RBITS-1:0]               o_reg_rs;
  logic [RBITS-1:0]               o_reg_rt;
  logic [RBITS-1:0]               o_reg_rd;
  logic [CANT_BITS_CTRL-1:0]      o_ctrl;
  logic                           o_halt_detected;
  logic                           o_halted;
  logic [15:0]                    o_bubble_count;

  modport master (
    output i_enable_pipeline, i_valid, i_bubble, i_flush, i_halt, i_zero_extend,
           i_pc, i_data_A, i_data_B, i_immediate, i_reg_rs, i_reg_rt, i_reg_rd,
           i_ctrl, i_control_write_reg, i_reg_write, i_data_write,
    input  o_valid, o_pc, o_data_A, o_data_B, o_extension_constante,
           o_reg_rs, o_reg_rt, o_reg_rd, o_ctrl, o_halt_detected, o_halted,
           o_bubble_count
  );

  modport slave (
    input  i_enable_pipeline, i_valid, i_bubble, i_flush, i_halt, i_zero_extend,
           i_pc, i_data_A, i_data_B, i_immediate, i_reg_rs, i_reg_rt, i_reg_rd,
           i_ctrl, i_control_write_reg, i_reg_write, i_data_write,
    output o_valid, o_pc, o_data_A, o_data_B, o_extension_constante,
           o_reg_rs, o_reg_rt, o_reg_rd, o_ctrl, o_halt_detected, o_halted,
           o_bubble_count
  );
endinterface

// File: rtl/id_ex_stage_register_halt_drain_fsm.sv
// rtl/id_ex_stage_register_halt_drain_fsm.sv - halt capture and drain countdown to the sticky halted flag
module halt_drain_fsm
  import id_ex_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic         i_clock,
  input  logic         i_soft_reset,
  input  logic         i_enable,
  input  logic         i_capture,
  output drain_state_e o_state,
  output logic         o_halt_detected,
  output logic         o_halted
);

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  drain_state_e state_q;
  logic [7:0]   drain_cnt_q;
  logic         halt_detected_q;
  logic         halted_q;

  // The counter starts at DRAIN_CYCLES-1 and the HALTED step consumes the final edge.
  always_ff @(negedge i_clock) begin
    if (i_soft_reset) begin
      state_q         <= RUN;
      drain_cnt_q     <= 8'd0;
      halt_detected_q <= 1'b0;
      halted_q        <= 1'b0;
    end else if (i_enable) begin
      case (state_q)
        RUN: begin
          if (i_capture) begin
            state_q         <= DRAIN;
            drain_cnt_q     <= DRAIN_LOAD;
            halt_detected_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == 8'd0) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 8'd1;
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  assign o_state         = state_q;
  assign o_halt_detected = halt_detected_q;
  assign o_halted        = halted_q;

endmodule

// File: rtl/id_ex_stage_register.sv
// rtl/id_ex_stage_register.sv - ID/EX pipeline register, falling-edge; WB->ID bypass under ID_WB_BYPASS_EN
module id_ex_stage_register
  import id_ex_pkg::*;
#(
  parameter int                             CANT_BITS_ADDR      = 11,
  parameter int                             CANT_BITS_REGISTROS = 32,
  parameter int                             CANT_REGISTROS      = 32,
  parameter int                             CANT_BITS_IMMEDIATE = 16,
  parameter int                             CANT_BITS_CTRL      = 16,
  parameter logic [CANT_BITS_CTRL-1:0]      CTRL_NOP            = CANT_BITS_CTRL'(CTRL_NOP_DEFAULT),
  parameter int                             DRAIN_CYCLES        = 4
) (
  input logic                   i_clock,
  input logic                   i_soft_reset,
  id_ex_stage_register_if.slave bus
);

  localparam int RBITS = $clog2(CANT_REGISTROS);
  localparam int EXT_W = CANT_BITS_REGISTROS - CANT_BITS_IMMEDIATE;

  logic                           valid_q, valid_d;
  logic [CANT_BITS_ADDR-1:0]      pc_q, pc_d;
  logic [CANT_BITS_REGISTROS-1:0] data_a_q, data_a_d;
  logic [CANT_BITS_REGISTROS-1:0] data_b_q, data_b_d;
  logic [CANT_BITS_REGISTROS-1:0] ext_q, ext_d;
  logic [RBITS-1:0]               rs_q, rs_d;
  logic [RBITS-1:0]               rt_q, rt_d;
  logic [RBITS-1:0]               rd_q, rd_d;
  logic [CANT_BITS_CTRL-1:0]      ctrl_q, ctrl_d;
  logic [15:0]                    bubble_cnt_q, bubble_cnt_d;

  drain_state_e                   fsm_state;
  logic                           run;
  logic                           kill;
  logic                           capture;
  logic [CANT_BITS_REGISTROS-1:0] operand_a;
  logic [CANT_BITS_REGISTROS-1:0] operand_b;
  logic [CANT_BITS_REGISTROS-1:0] imm_ext;

  assign run     = (fsm_state == RUN);
  assign kill    = bus.i_flush | bus.i_bubble;
  // A killed or stalled ID instruction never reaches EX, so its halt is dropped.
  assign capture = run & ~kill & bus.i_valid & bus.i_halt;

  assign imm_ext = bus.i_zero_extend
                 ? {{EXT_W{1'b0}}, bus.i_immediate}
                 : {{EXT_W{bus.i_immediate[CANT_BITS_IMMEDIATE-1]}}, bus.i_immediate};

`ifdef ID_WB_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  // Covers the WB write landing in the register file during the same cycle as the read.
  assign fwd_a     = bus.i_control_write_reg && (bus.i_reg_write == bus.i_reg_rs) && (bus.i_reg_write != '0);
  assign fwd_b     = bus.i_control_write_reg && (bus.i_reg_write == bus.i_reg_rt) && (bus.i_reg_write != '0);
  assign operand_a = fwd_a ? bus.i_data_write : bus.i_data_A;
  assign operand_b = fwd_b ? bus.i_data_write : bus.i_data_B;
`else
  logic unused_bypass;

  assign operand_a     = bus.i_data_A;
  assign operand_b     = bus.i_data_B;
  assign unused_bypass = ^{bus.i_control_write_reg, bus.i_reg_write, bus.i_data_write};
`endif

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    ext_d        = ext_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!run) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (kill) begin
      valid_d      = 1'b0;
      ctrl_d       = CTRL_NOP;
      bubble_cnt_d = sat_inc16(bubble_cnt_q);
    end else begin
      valid_d  = bus.i_valid;
      pc_d     = bus.i_pc;
      data_a_d = operand_a;
      data_b_d = operand_b;
      ext_d    = imm_ext;
      rs_d     = bus.i_reg_rs;
      rt_d     = bus.i_reg_rt;
      rd_d     = bus.i_reg_rd;
      // The halt instruction itself travels as a valid NOP.
      ctrl_d   = (bus.i_valid && !bus.i_halt) ? bus.i_ctrl : CTRL_NOP;
    end
  end

  always_ff @(negedge i_clock) begin
    if (i_soft_reset) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      ext_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      ctrl_q       <= CTRL_NOP;
      bubble_cnt_q <= 16'd0;
    end else if (bus.i_enable_pipeline) begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      ext_q        <= ext_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  halt_drain_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_drain_fsm (
    .i_clock         (i_clock),
    .i_soft_reset    (i_soft_reset),
    .i_enable        (bus.i_enable_pipeline),
    .i_capture       (capture),
    .o_state         (fsm_state),
    .o_halt_detected (bus.o_halt_detected),
    .o_halted        (bus.o_halted)
  );

  assign bus.o_valid               = valid_q;
  assign bus.o_pc                  = pc_q;
  assign bus.o_data_A              = data_a_q;
  assign bus.o_data_B              = data_b_q;
  assign bus.o_extension_constante = ext_q;
  assign bus.o_reg_rs              = rs_q;
  assign bus.o_reg_rt              = rt_q;
  assign bus.o_reg_rd              = rd_q;
  assign bus.o_ctrl                = ctrl_q;
  assign bus.o_bubble_count        = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb/tb_id_ex_stage_register.sv - vector table, corner sequences and random run against a reference model
module tb_id_ex_stage_register;

  localparam int          DRAIN = 4;
  localparam logic [15:0] NOP   = 16'h0200;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage_register_if bus ();

  id_ex_stage_register dut (
    .i_clock      (clk),
    .i_soft_reset (rst),
    .bus          (bus.slave)
  );

  // Reference model state
  logic        m_valid;
  logic [10:0] m_pc;
  logic [31:0] m_a, m_b, m_ext;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [15:0] m_ctrl;
  logic        m_hd, m_halted;
  int          m_bc, m_seen;

  typedef struct {
    logic        valid;
    logic        zext;
    logic        halt;
    logic [15:0] imm;
    logic [15:0] ctrl;
    logic        exp_valid;
    logic [31:0] exp_ext;
    logic [15:0] exp_ctrl;
    logic        exp_hd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_WB_BYPASS_EN
    if (bus.i_control_write_reg && idx != 0 && idx == bus.i_reg_write) return bus.i_data_write;
`endif
    return (idx === 5'bx) ? rf : rf;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_ext = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = NOP;
      m_hd = 0; m_halted = 0; m_bc = 0; m_seen = 0;
    end else if (bus.i_enable_pipeline) begin
      if (m_hd) begin
        m_valid = 0;
        m_ctrl  = NOP;
        if (!m_halted) begin
          m_seen++;
          if (m_seen == DRAIN) m_halted = 1;
        end
      end else if (bus.i_flush || bus.i_bubble) begin
        m_valid = 0;
        m_ctrl  = NOP;
        m_bc    = (m_bc < 65535) ? m_bc + 1 : 65535;
      end else begin
        m_valid = bus.i_valid;
        m_pc    = bus.i_pc;
        m_a     = model_operand(bus.i_reg_rs, bus.i_data_A);
        m_b     = model_operand(bus.i_reg_rt, bus.i_data_B);
        m_ext   = bus.i_zero_extend ? 32'(bus.i_immediate) : 32'($signed(bus.i_immediate));
        m_rs    = bus.i_reg_rs;
        m_rt    = bus.i_reg_rt;
        m_rd    = bus.i_reg_rd;
        m_ctrl  = (bus.i_valid && !bus.i_halt) ? bus.i_ctrl : NOP;
        if (bus.i_valid && bus.i_halt) begin
          m_hd   = 1;
          m_seen = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0;
    bus.i_enable_pipeline = 1; bus.i_valid = 0; bus.i_bubble = 0; bus.i_flush = 0;
    bus.i_halt = 0; bus.i_zero_extend = 0; bus.i_pc = 0; bus.i_data_A = 0; bus.i_data_B = 0;
    bus.i_immediate = 0; bus.i_reg_rs = 0; bus.i_reg_rt = 0; bus.i_reg_rd = 0; bus.i_ctrl = 0;
    bus.i_control_write_reg = 0; bus.i_reg_write = 0; bus.i_data_write = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic check_model();
    chk("valid", 64'(bus.o_valid), 64'(m_valid));
    chk("pc", 64'(bus.o_pc), 64'(m_pc));
    chk("data_A", 64'(bus.o_data_A), 64'(m_a));
    chk("data_B", 64'(bus.o_data_B), 64'(m_b));
    chk("ext", 64'(bus.o_extension_constante), 64'(m_ext));
    chk("rs/rt/rd", 64'({bus.o_reg_rs, bus.o_reg_rt, bus.o_reg_rd}), 64'({m_rs, m_rt, m_rd}));
    chk("ctrl", 64'(bus.o_ctrl), 64'(m_ctrl));
    chk("halt_detected", 64'(bus.o_halt_detected), 64'(m_hd));
    chk("halted", 64'(bus.o_halted), 64'(m_halted));
    chk("bubble_count", 64'(bus.o_bubble_count), 64'(m_bc));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h8001, 16'h1234, 1'b1, 32'hFFFF8001, 16'h1234, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h8001, 16'h1234, 1'b1, 32'h00008001, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h7FFF, 16'hABCD, 1'b1, 32'h00007FFF, 16'hABCD, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0F0F, 1'b1, 32'h0000FFFF, 16'h0F0F, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h8000, 16'h1234, 1'b0, 32'hFFFF8000, 16'h0200, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'hFFFF, 1'b1, 32'h00000004, 16'h0200, 1'b1};

    do_reset();
    chk("reset valid", 64'(bus.o_valid), 64'd0);
    chk("reset ctrl", 64'(bus.o_ctrl), 64'h0200);
    chk("reset data_A", 64'(bus.o_data_A), 64'd0);
    chk("reset ext", 64'(bus.o_extension_constante), 64'd0);
    chk("reset flags", 64'({bus.o_halt_detected, bus.o_halted}), 64'd0);
    chk("reset bubble_count", 64'(bus.o_bubble_count), 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.i_valid = vecs[i].valid; bus.i_zero_extend = vecs[i].zext; bus.i_halt = vecs[i].halt;
      bus.i_immediate = vecs[i].imm; bus.i_ctrl = vecs[i].ctrl;
      step();
      chk($sformatf("vec%0d valid", i), 64'(bus.o_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d ext", i), 64'(bus.o_extension_constante), 64'(vecs[i].exp_ext));
      chk($sformatf("vec%0d ctrl", i), 64'(bus.o_ctrl), 64'(vecs[i].exp_ctrl));
      chk($sformatf("vec%0d halt_detected", i), 64'(bus.o_halt_detected), 64'(vecs[i].exp_hd));
    end

    // Bubble and flush together for three cycles
    do_reset();
    bus.i_valid = 1; bus.i_data_A = 32'h11111111; bus.i_pc = 11'h123; bus.i_ctrl = 16'h00FF;
    step();
    bus.i_data_A = 32'h22222222; bus.i_pc = 11'h456; bus.i_bubble = 1; bus.i_flush = 1;
    repeat (3) step();
    chk("bf ctrl", 64'(bus.o_ctrl), 64'h0200);
    chk("bf valid", 64'(bus.o_valid), 64'd0);
    chk("bf bubble_count", 64'(bus.o_bubble_count), 64'd3);
    chk("bf data_A held", 64'(bus.o_data_A), 64'h11111111);
    chk("bf pc held", 64'(bus.o_pc), 64'h123);

    // Halt drains for exactly DRAIN enabled edges, then flush is ignored
    do_reset();
    bus.i_valid = 1; bus.i_halt = 1; bus.i_ctrl = 16'h1234;
    step();
    chk("halt N detected", 64'(bus.o_halt_detected), 64'd1);
    chk("halt N valid", 64'(bus.o_valid), 64'd1);
    chk("halt N ctrl", 64'(bus.o_ctrl), 64'h0200);
    chk("halt N halted", 64'(bus.o_halted), 64'd0);
    idle();
    bus.i_valid = 1; bus.i_ctrl = 16'h1234;
    for (int k = 1; k <= DRAIN; k++) begin
      step();
      chk($sformatf("halt N+%0d halted", k), 64'(bus.o_halted), 64'(k == DRAIN));
      chk($sformatf("halt N+%0d valid", k), 64'(bus.o_valid), 64'd0);
    end
    bus.i_flush = 1;
    step();
    chk("halted flush count", 64'(bus.o_bubble_count), 64'd0);
    chk("halted flush ctrl", 64'(bus.o_ctrl), 64'h0200);
    chk("halted sticky", 64'(bus.o_halted), 64'd1);

    // Halt discarded by simultaneous flush, then by simultaneous bubble
    do_reset();
    bus.i_valid = 1; bus.i_halt = 1; bus.i_flush = 1;
    step();
    chk("halt+flush detected", 64'(bus.o_halt_detected), 64'd0);
    bus.i_halt = 0; bus.i_flush = 0; bus.i_ctrl = 16'h1234;
    step();
    chk("after halt+flush valid", 64'(bus.o_valid), 64'd1);
    chk("after halt+flush ctrl", 64'(bus.o_ctrl), 64'h1234);
    bus.i_halt = 1; bus.i_bubble = 1;
    step();
    chk("halt+bubble detected", 64'(bus.o_halt_detected), 64'd0);
    chk("halt+bubble count", 64'(bus.o_bubble_count), 64'd2);

    // Enable low for two cycles mid-drain, then reset from HALTED
    do_reset();
    bus.i_valid = 1; bus.i_halt = 1; bus.i_data_A = 32'hCAFE0001; bus.i_immediate = 16'h8000;
    bus.i_pc = 11'h7FF;
    step();
    bus.i_halt = 0;
    step();
    bus.i_enable_pipeline = 0;
    repeat (2) step();
    chk("stall halted", 64'(bus.o_halted), 64'd0);
    bus.i_enable_pipeline = 1;
    repeat (2) step();
    chk("stretched drain not yet", 64'(bus.o_halted), 64'd0);
    step();
    chk("stretched drain halted", 64'(bus.o_halted), 64'd1);
    rst = 1;
    step();
    rst = 0;
    chk("rst halted valid", 64'(bus.o_valid), 64'd0);
    chk("rst halted ctrl", 64'(bus.o_ctrl), 64'h0200);
    chk("rst halted flags", 64'({bus.o_halt_detected, bus.o_halted}), 64'd0);
    chk("rst halted data", 64'({bus.o_data_A, bus.o_extension_constante}), 64'd0);
    chk("rst halted pc", 64'(bus.o_pc), 64'd0);
    bus.i_halt = 1;
    step();
    chk("rst back to RUN", 64'(bus.o_halt_detected), 64'd1);

`ifdef ID_WB_BYPASS_EN
    do_reset();
    bus.i_valid = 1; bus.i_reg_rs = 5; bus.i_reg_write = 5; bus.i_control_write_reg = 1;
    bus.i_data_write = 32'hDEADBEEF; bus.i_data_A = 32'h12345678;
    step();
    chk("bypass rs5", 64'(bus.o_data_A), 64'hDEADBEEF);
    bus.i_reg_rs = 0; bus.i_reg_write = 0;
    step();
    chk("bypass r0", 64'(bus.o_data_A), 64'h12345678);
`endif

    // Randomised run against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      bus.i_enable_pipeline = ($urandom_range(7) != 0);
      bus.i_valid = ($urandom_range(3) != 0);
      bus.i_bubble = ($urandom_range(7) == 0);
      bus.i_flush = ($urandom_range(9) == 0);
      bus.i_halt = ($urandom_range(39) == 0);
      bus.i_zero_extend = $urandom_range(1);
      bus.i_pc = 11'($urandom);
      bus.i_data_A = $urandom;
      bus.i_data_B = $urandom;
      bus.i_immediate = 16'($urandom);
      bus.i_reg_rs = 5'($urandom_range(7));
      bus.i_reg_rt = 5'($urandom_range(7));
      bus.i_reg_rd = 5'($urandom);
      bus.i_ctrl = 16'($urandom);
      bus.i_control_write_reg = $urandom_range(1);
      bus.i_reg_write = 5'($urandom_range(7));
      bus.i_data_write = $urandom;
      step();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
